// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: N-input, WIDTH-bit multiplexer with a registered output.
// Two select modes: manual (external sel) and scan (an internal dwell
// counter walks the channels enabled by ch_mask). dout and cur_sel are
// written on the same edge from the same computed pointer, so they never skew.
//
// Handshake: there is no valid/ready flow control. en is a pure qualifier:
// en=1 lets the edge update state, en=0 freezes every register except wrap,
// which is forced low. dout_valid=1 means dout carries the data of the legal
// channel named by cur_sel as sampled on the last updating edge.
//
// state_dbg exposes the FSM state: 0=IDLE, 1=MANUAL, 2=SCAN.
module mux_nto1_scan #(
  parameter int N     = 8,
  parameter int WIDTH = 1,
  parameter int SEL_W = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 en,
  input  logic [N-1:0]         ch_mask,
  output logic [WIDTH-1:0]     dout,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 dout_valid,
  output logic                 wrap,
  output logic [1:0]           state_dbg
);

  // Counter needs at least one bit even when DWELL=1 (it then stays at 0).
  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic [WIDTH-1:0]  dout_nx;
  logic              valid_nx;
  logic              wrap_nx;
  logic              entering_scan;
  logic              cur_enabled;
  logic [SEL_W-1:0]  succ_sel;

  // Channel idx of the packed input bus.
  function automatic logic [WIDTH-1:0] slice_of(input logic [N*WIDTH-1:0] d,
                                                input logic [SEL_W-1:0]   idx);
    return WIDTH'(d >> (int'(idx) * WIDTH));
  endfunction

  // Mask bit for channel idx (idx is always < N when called).
  function automatic logic mask_bit(input logic [N-1:0]     m,
                                    input logic [SEL_W-1:0] idx);
    return 1'(m >> int'(idx));
  endfunction

  // First enabled channel searching upward circularly from 'from'+1.
  // 'from' itself is the last candidate, so a lone enabled channel
  // re-selects itself. Returns 'from' when the mask is empty.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [N-1:0]     m,
                                                    input logic [SEL_W-1:0] from);
    logic [SEL_W-1:0] r;
    logic             found;
    int               idx;
    r     = from;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(from) + i) % N;
      if (!found && 1'(m >> idx)) begin
        r     = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign state_dbg     = state;
  assign entering_scan = (state != ST_SCAN);
  assign cur_enabled   = mask_bit(ch_mask, cur_sel);
  assign succ_sel      = next_enabled(ch_mask, cur_sel);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: any enabled edge lands in the mode's state; en=0 holds.
  always_comb begin
    state_nx = state;
    if (en) begin
      state_nx = mode ? ST_SCAN : ST_MANUAL;
    end
  end

  // Output/datapath next values for the state being entered on this edge.
  always_comb begin
    sel_nx   = cur_sel;
    cnt_nx   = cnt;
    dout_nx  = dout;
    valid_nx = dout_valid;
    wrap_nx  = 1'b0;
    if (en) begin
      if (state_nx == ST_MANUAL) begin
        cnt_nx = '0;
        if (int'(sel) < N) begin
          sel_nx   = sel;
          dout_nx  = slice_of(din, sel);
          valid_nx = 1'b1;
        end else begin
          dout_nx  = '0;
          valid_nx = 1'b0;
        end
      end else begin
        if (ch_mask == '0) begin
          // Nothing to scan: park pointer and counter, blank the output.
          if (entering_scan) begin
            cnt_nx = '0;
          end
          dout_nx  = '0;
          valid_nx = 1'b0;
        end else begin
          if (entering_scan) begin
            // Entry edge: keep cur_sel if it is enabled, never pulse wrap.
            cnt_nx = '0;
            if (!cur_enabled) begin
              sel_nx = succ_sel;
            end
          end else if (!cur_enabled || (cnt == CNT_LAST)) begin
            // Dwell done, or current channel was masked off mid-dwell.
            cnt_nx  = '0;
            sel_nx  = succ_sel;
            wrap_nx = (succ_sel <= cur_sel);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
          dout_nx  = slice_of(din, sel_nx);
          valid_nx = 1'b1;
        end
      end
    end
  end

  // Datapath registers; dout and cur_sel always move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cur_sel    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      cur_sel    <= sel_nx;
      dout       <= dout_nx;
      dout_valid <= valid_nx;
      wrap       <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: two instances (N=8/WIDTH=1/DWELL=4 and
// N=5/WIDTH=8/DWELL=1) driven side by side, each checked every cycle
// against a behavioural model of the channel-selection rules.
module tb_mux_nto1_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT A: N=8, WIDTH=1, DWELL=4 ----------------
  logic [7:0] a_din;
  logic [2:0] a_sel;
  logic       a_mode, a_en;
  logic [7:0] a_mask;
  logic       a_dout;
  logic [2:0] a_cur;
  logic       a_valid, a_wrap;
  logic [1:0] a_st;

  mux_nto1_scan #(.N(8), .WIDTH(1), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .sel(a_sel), .mode(a_mode),
    .en(a_en), .ch_mask(a_mask), .dout(a_dout), .cur_sel(a_cur),
    .dout_valid(a_valid), .wrap(a_wrap), .state_dbg(a_st)
  );

  // ---------------- DUT B: N=5, WIDTH=8, DWELL=1 ----------------
  logic [39:0] b_din;
  logic [2:0]  b_sel;
  logic        b_mode, b_en;
  logic [4:0]  b_mask;
  logic [7:0]  b_dout;
  logic [2:0]  b_cur;
  logic        b_valid, b_wrap;
  logic [1:0]  b_st;

  mux_nto1_scan #(.N(5), .WIDTH(8), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .sel(b_sel), .mode(b_mode),
    .en(b_en), .ch_mask(b_mask), .dout(b_dout), .cur_sel(b_cur),
    .dout_valid(b_valid), .wrap(b_wrap), .state_dbg(b_st)
  );

  // ---------------- scoreboard ----------------
  int vectors    = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 manual, 2 scan
  int          m_phase[2];
  int          m_sel[2];
  int          m_cnt[2];
  logic [63:0] m_dout[2];
  bit          m_valid[2];
  bit          m_wrap[2];

  function automatic logic [63:0] slice(input logic [63:0] d, input int idx, input int width);
    logic [63:0] msk;
    msk = (64'd1 << width) - 64'd1;
    return (d >> (idx * width)) & msk;
  endfunction

  // Next enabled channel after 'old', wrapping to the lowest enabled one.
  function automatic int succ(input logic [63:0] mask, input int n, input int old);
    int q[$];
    int nxt;
    for (int k = 0; k < n; k++) if (mask[k]) q.push_back(k);
    nxt = -1;
    foreach (q[j]) if (nxt < 0 && q[j] > old) nxt = q[j];
    if (nxt < 0) nxt = q[0];
    return nxt;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_phase[id] = 0; m_sel[id] = 0; m_cnt[id] = 0;
      m_dout[id] = '0; m_valid[id] = 0; m_wrap[id] = 0;
    end
  endtask

  task automatic model_step(input int id, input int n, input int dwell, input int width,
                            input logic [63:0] d, input int sel, input bit mode,
                            input bit en, input logic [63:0] mask);
    bit entering;
    int old;
    logic [63:0] live;
    m_wrap[id] = 0;
    if (!en) return;
    if (!mode) begin
      m_phase[id] = 1;
      m_cnt[id]   = 0;
      if (sel < n) begin
        m_sel[id] = sel; m_dout[id] = slice(d, sel, width); m_valid[id] = 1;
      end else begin
        m_dout[id] = '0; m_valid[id] = 0;
      end
      return;
    end
    entering    = (m_phase[id] != 2);
    m_phase[id] = 2;
    live = mask & ((64'd1 << n) - 64'd1);
    if (live == '0) begin
      if (entering) m_cnt[id] = 0;
      m_dout[id] = '0; m_valid[id] = 0;
      return;
    end
    old = m_sel[id];
    if (entering) begin
      m_cnt[id] = 0;
      if (!mask[old]) m_sel[id] = succ(mask, n, old);
    end else if (!mask[old] || m_cnt[id] == dwell - 1) begin
      m_cnt[id]  = 0;
      m_sel[id]  = succ(mask, n, old);
      m_wrap[id] = (m_sel[id] <= old);
    end else begin
      m_cnt[id]++;
    end
    m_dout[id]  = slice(d, m_sel[id], width);
    m_valid[id] = 1;
  endtask

  task automatic push_exp();
    for (int id = 0; id < 2; id++) begin
      exp_q.push_back(m_dout[id]);
      exp_q.push_back(64'(m_sel[id]));
      exp_q.push_back(64'(m_valid[id]));
      exp_q.push_back(64'(m_wrap[id]));
    end
  endtask

  task automatic check_all();
    push_exp();
    chk("a_dout",  64'(a_dout),  exp_q.pop_front());
    chk("a_cur",   64'(a_cur),   exp_q.pop_front());
    chk("a_valid", 64'(a_valid), exp_q.pop_front());
    chk("a_wrap",  64'(a_wrap),  exp_q.pop_front());
    chk("b_dout",  64'(b_dout),  exp_q.pop_front());
    chk("b_cur",   64'(b_cur),   exp_q.pop_front());
    chk("b_valid", 64'(b_valid), exp_q.pop_front());
    chk("b_wrap",  64'(b_wrap),  exp_q.pop_front());
  endtask

  // ---------------- driver ----------------
  // One active edge: model both DUTs on the sampled inputs, check #1 later.
  task automatic tick();
    @(posedge clk);
    model_step(0, 8, 4, 1, 64'(a_din), int'(a_sel), a_mode, a_en, 64'(a_mask));
    model_step(1, 5, 1, 8, 64'(b_din), int'(b_sel), b_mode, b_en, 64'(b_mask));
    #1;
    check_all();
  endtask

  task automatic rand_din();
    a_din = 8'($urandom);
    b_din = {8'($urandom), 32'($urandom)};
  endtask

  int a_wraps, b_wraps;
  bit hit;

  initial begin
    rst = 1'b1;
    a_din = '0; a_sel = '0; a_mode = 1'b0; a_en = 1'b0; a_mask = '0;
    b_din = '0; b_sel = '0; b_mode = 1'b0; b_en = 1'b0; b_mask = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Manual sweep
    a_din = 8'b1010_1101; a_mode = 1'b0; a_en = 1'b1;
    b_mode = 1'b0; b_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_sel = 3'(i);
      b_sel = 3'(i);
      b_din = {8'($urandom), 32'($urandom)};
      tick();
      chk("sweep_bit", 64'(a_dout), 64'((8'hAD >> i) & 8'h1));
      if (i >= 5) begin
        chk("b_bad_sel_valid", 64'(b_valid), 64'd0);
        chk("b_bad_sel_dout",  64'(b_dout),  64'd0);
      end
    end

    // Full-mask scan from reset
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    a_mode = 1'b1; a_mask = 8'hFF; b_mode = 1'b1; b_mask = 5'h1F;
    a_wraps = 0; b_wraps = 0;
    for (int i = 0; i < 33; i++) begin
      rand_din();
      tick();
      a_wraps += int'(a_wrap);
      b_wraps += int'(b_wrap);
    end
    chk("a_fullmask_wraps", 64'(a_wraps), 64'd1);
    chk("a_fullmask_end_ch", 64'(a_cur), 64'd0);
    chk("b_fullmask_wraps", 64'(b_wraps), 64'd6);

    // Sparse mask, then clear bit 2 while on channel 2 at count 1
    a_mask = 8'b0010_0101;
    for (int i = 0; i < 12; i++) begin rand_din(); tick(); end
    hit = 0;
    for (int g = 0; g < 40 && !hit; g++) begin
      rand_din(); tick();
      hit = (m_sel[0] == 2 && m_cnt[0] == 1);
    end
    chk("reach_ch2_cnt1", 64'(hit), 64'd1);
    a_mask = 8'b0010_0001;
    rand_din(); tick();
    chk("midclr_ch", 64'(a_cur), 64'd5);

    // Manual at sel=3, then scan entry with the sparse mask
    a_mode = 1'b0; a_sel = 3'd3; rand_din(); tick();
    a_mode = 1'b1; a_mask = 8'b0010_0101; rand_din(); tick();
    chk("entry_ch", 64'(a_cur), 64'd5);
    chk("entry_wrap", 64'(a_wrap), 64'd0);
    for (int i = 0; i < 8; i++) begin rand_din(); tick(); end

    // Empty mask, then a single-channel mask
    a_mask = 8'h00; b_mask = 5'h00;
    for (int i = 0; i < 6; i++) begin rand_din(); tick(); end
    chk("empty_valid", 64'(a_valid), 64'd0);
    a_mask = 8'b0000_1000; b_mask = 5'b00100;
    for (int i = 0; i < 12; i++) begin rand_din(); tick(); end
    chk("single_ch", 64'(a_cur), 64'd3);

    // Enable gating mid-dwell
    a_mask = 8'hFF; b_mask = 5'h1F;
    hit = 0;
    for (int g = 0; g < 20 && !hit; g++) begin
      rand_din(); tick();
      hit = (m_cnt[0] == 1);
    end
    chk("reach_cnt1", 64'(hit), 64'd1);
    a_en = 1'b0;
    for (int i = 0; i < 6; i++) begin rand_din(); tick(); end
    a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_din(); tick(); end

    // Async reset between edges, mid-scan
    #2; rst = 1'b1; #1;
    model_reset();
    check_all();
    #1; rst = 1'b0;
    a_en = 1'b0; b_en = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_din(); tick(); end
    a_en = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 6; i++) begin rand_din(); tick(); end

    // Random mix of modes, enables, masks and selects
    for (int i = 0; i < 250; i++) begin
      rand_din();
      if ($urandom_range(0, 9) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 9) == 0) b_mode = ~b_mode;
      a_en  = ($urandom_range(0, 7) != 0);
      b_en  = ($urandom_range(0, 7) != 0);
      a_sel = 3'($urandom_range(0, 7));
      b_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: begin a_mask = 8'h00; b_mask = 5'h00; end
          1: begin a_mask = 8'(1 << $urandom_range(0, 7)); b_mask = 5'(1 << $urandom_range(0, 4)); end
          default: begin a_mask = 8'($urandom); b_mask = 5'($urandom); end
        endcase
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
